// File: rtl/rf_write_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | rf_write_arbiter_pkg: shared widths and grant encoding for the RF write   |
// | arbiter.  Revision: 1.0                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifndef WORD_LEN
`define WORD_LEN 32
`endif
`ifndef REG_FILE_ADDR_LEN
`define REG_FILE_ADDR_LEN 5
`endif
`ifndef REG_FILE_SIZE
`define REG_FILE_SIZE 32
`endif
`ifndef RF_STARVE_LIMIT
`define RF_STARVE_LIMIT 4
`endif

package rf_write_arbiter_pkg;
  localparam int WORD_W          = `WORD_LEN;
  localparam int RF_ADDR_W       = `REG_FILE_ADDR_LEN;
  localparam int RF_SIZE         = `REG_FILE_SIZE;
  localparam int RF_STARVE_LIMIT = `RF_STARVE_LIMIT;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_A    = 2'd1,
    GNT_B    = 2'd2
  } grant_e;
endpackage

`default_nettype wire

// File: rtl/rf_write_arbiter_scoreboard.sv
// +----------------------------------------------------------------------------+
// | rf_write_arbiter_scoreboard: busy bits for registers with an outstanding   |
// | multi-cycle write.  Revision: 1.0                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module rf_scoreboard
  import rf_write_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_set_en,
  input  logic [RF_ADDR_W-1:0] i_set_idx,
  input  logic                 i_clr_en,
  input  logic [RF_ADDR_W-1:0] i_clr_idx,
  output logic [RF_SIZE-1:0]   o_busy
);

  logic [RF_SIZE-1:0] r_busy;
  logic [RF_SIZE-1:0] w_set_mask;
  logic [RF_SIZE-1:0] w_clr_mask;
  logic [RF_SIZE-1:0] w_busy_next;

  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (i_set_en && (i_set_idx != '0)) w_set_mask[i_set_idx] = 1'b1;
    if (i_clr_en) w_clr_mask[i_clr_idx] = 1'b1;
    // A same-cycle reservation belongs to a newer op, so set overrides clear
    w_busy_next    = (r_busy & ~w_clr_mask) | w_set_mask;
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_next;
  end

  assign o_busy = r_busy;

endmodule

`default_nettype wire

// File: rtl/rf_write_arbiter.sv
// +----------------------------------------------------------------------------+
// | rf_write_arbiter: shares the RF write port between WB (A, priority) and a  |
// | multi-cycle unit (B) with a starvation guard.  Revision: 1.0               |
// +----------------------------------------------------------------------------+
`default_nettype none

module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = RF_STARVE_LIMIT,
  parameter int CNT_W        = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_a_valid,
  input  logic [RF_ADDR_W-1:0] i_a_dest,
  input  logic [WORD_W-1:0]    i_a_data,
  output logic                 o_a_ready,
  input  logic                 i_b_valid,
  input  logic [RF_ADDR_W-1:0] i_b_dest,
  input  logic [WORD_W-1:0]    i_b_data,
  output logic                 o_b_ready,
  input  logic                 i_rsv_valid,
  input  logic [RF_ADDR_W-1:0] i_rsv_dest,
  output logic                 o_wr_en,
  output logic [RF_ADDR_W-1:0] o_wr_dest,
  output logic [WORD_W-1:0]    o_wr_data,
  output logic [RF_SIZE-1:0]   o_busy
);

  localparam logic [CNT_W-1:0] c_LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]     r_starve_cnt;
  logic                 r_wr_en;
  logic [RF_ADDR_W-1:0] r_wr_dest;
  logic [WORD_W-1:0]    r_wr_data;

  logic                 w_force;
  logic                 w_a_fire;
  logic                 w_b_fire;
  grant_e               w_grant;
  logic [RF_ADDR_W-1:0] w_win_dest;
  logic [WORD_W-1:0]    w_win_data;

  assign w_force   = (r_starve_cnt == c_LIMIT);
  assign o_a_ready = ~w_force;
  assign o_b_ready = w_force | ~i_a_valid;
  assign w_a_fire  = i_a_valid & o_a_ready;
  assign w_b_fire  = i_b_valid & o_b_ready;

  always_comb begin
    w_grant    = GNT_NONE;
    w_win_dest = r_wr_dest;
    w_win_data = r_wr_data;
    if (w_a_fire) begin
      w_grant    = GNT_A;
      w_win_dest = i_a_dest;
      w_win_data = i_a_data;
    end else if (w_b_fire) begin
      w_grant    = GNT_B;
      w_win_dest = i_b_dest;
      w_win_data = i_b_data;
    end
  end

  // The counter never sits at the limit past a forced cycle since B fires there
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (!i_b_valid || w_b_fire) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != c_LIMIT) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en   <= 1'b0;
      r_wr_dest <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en   <= (w_grant != GNT_NONE) && (w_win_dest != '0);
      r_wr_dest <= w_win_dest;
      r_wr_data <= w_win_data;
    end
  end

  assign o_wr_en   = r_wr_en;
  assign o_wr_dest = r_wr_dest;
  assign o_wr_data = r_wr_data;

  rf_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .i_set_en  (i_rsv_valid),
    .i_set_idx (i_rsv_dest),
    .i_clr_en  (w_b_fire),
    .i_clr_idx (i_b_dest),
    .o_busy    (o_busy)
  );

endmodule

`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_rf_write_arbiter: directed self-checking bench for rf_write_arbiter.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_rf_write_arbiter;
  import rf_write_arbiter_pkg::*;

  logic                 clk;
  logic                 rst;
  logic                 a_valid;
  logic [RF_ADDR_W-1:0] a_dest;
  logic [WORD_W-1:0]    a_data;
  logic                 a_ready;
  logic                 b_valid;
  logic [RF_ADDR_W-1:0] b_dest;
  logic [WORD_W-1:0]    b_data;
  logic                 b_ready;
  logic                 rsv_valid;
  logic [RF_ADDR_W-1:0] rsv_dest;
  logic                 wr_en;
  logic [RF_ADDR_W-1:0] wr_dest;
  logic [WORD_W-1:0]    wr_data;
  logic [RF_SIZE-1:0]   busy;

  int n_tests;
  int n_fail;

  rf_write_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_a_valid   (a_valid),
    .i_a_dest    (a_dest),
    .i_a_data    (a_data),
    .o_a_ready   (a_ready),
    .i_b_valid   (b_valid),
    .i_b_dest    (b_dest),
    .i_b_data    (b_data),
    .o_b_ready   (b_ready),
    .i_rsv_valid (rsv_valid),
    .i_rsv_dest  (rsv_dest),
    .o_wr_en     (wr_en),
    .o_wr_dest   (wr_dest),
    .o_wr_data   (wr_data),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid = 1'b0; a_dest = '0; a_data = '0;
    b_valid = 1'b0; b_dest = '0; b_data = '0;
    rsv_valid = 1'b0; rsv_dest = '0;
  endtask

  task automatic test_reset();
    tick();
    rsv_valid = 1'b1; rsv_dest = 5'd2;
    tick();
    rsv_dest = 5'd4;
    a_valid = 1'b1; a_dest = 5'd5; a_data = 32'h0000_CAFE;
    tick();
    n_tests++;
    if (busy !== 32'h0000_0014) begin
      n_fail++; $display("FAIL reset_pre_busy: got %h want %h", busy, 32'h14);
    end
    n_tests++;
    if (wr_en !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre_wr_en: got %b want 1", wr_en);
    end
    idle();
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({wr_en, wr_dest, wr_data, busy} !== '0) begin
      n_fail++; $display("FAIL reset_async_clear: wr_en=%b dest=%0d data=%h busy=%h want all 0",
                         wr_en, wr_dest, wr_data, busy);
    end
    tick();
    rst = 1'b0;
    #1;
    n_tests++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: a_ready=%b b_ready=%b want 1 1", a_ready, b_ready);
    end
    n_tests++;
    if (dut.r_starve_cnt !== 4'd0) begin
      n_fail++; $display("FAIL reset_starve_cnt: got %0d want 0", dut.r_starve_cnt);
    end
  endtask

  task automatic test_a_only();
    tick();
    a_valid = 1'b1; a_dest = 5'd5; a_data = 32'hDEAD_BEEF;
    #1;
    n_tests++;
    if (a_ready !== 1'b1) begin
      n_fail++; $display("FAIL a_only_ready: got %b want 1", a_ready);
    end
    tick();
    n_tests++;
    if (wr_en !== 1'b1 || wr_dest !== 5'd5 || wr_data !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL a_only_write: wr_en=%b dest=%0d data=%h want 1 5 deadbeef",
                         wr_en, wr_dest, wr_data);
    end
    idle();
    tick();
    n_tests++;
    if (wr_en !== 1'b0 || wr_dest !== 5'd5 || wr_data !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL a_only_hold: wr_en=%b dest=%0d data=%h want 0 5 deadbeef",
                         wr_en, wr_dest, wr_data);
    end
  endtask

  task automatic test_contention();
    logic exp_force;
    tick();
    a_valid = 1'b1; a_dest = 5'd3; a_data = 32'h0000_AAAA;
    b_valid = 1'b1; b_dest = 5'd7; b_data = 32'h0000_1234;
    for (int cyc = 0; cyc < 10; cyc++) begin
      exp_force = ((cyc % 5) == 4);
      #1;
      n_tests++;
      if (a_ready !== ~exp_force || b_ready !== exp_force) begin
        n_fail++; $display("FAIL contention_grant c%0d: a_ready=%b b_ready=%b want %b %b",
                           cyc, a_ready, b_ready, ~exp_force, exp_force);
      end
      tick();
      n_tests++;
      if (wr_en !== 1'b1 || wr_dest !== (exp_force ? 5'd7 : 5'd3) ||
          wr_data !== (exp_force ? 32'h0000_1234 : 32'h0000_AAAA)) begin
        n_fail++; $display("FAIL contention_write c%0d: wr_en=%b dest=%0d data=%h want 1 %0d",
                           cyc, wr_en, wr_dest, wr_data, exp_force ? 7 : 3);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_scoreboard();
    rsv_valid = 1'b1; rsv_dest = 5'd9;
    tick();
    rsv_valid = 1'b0;
    n_tests++;
    if (busy !== 32'h0000_0200) begin
      n_fail++; $display("FAIL sb_set: busy=%h want 00000200", busy);
    end
    b_valid = 1'b1; b_dest = 5'd9; b_data = 32'h0000_0099;
    #1;
    n_tests++;
    if (b_ready !== 1'b1) begin
      n_fail++; $display("FAIL sb_b_ready: got %b want 1", b_ready);
    end
    tick();
    n_tests++;
    if (busy[9] !== 1'b0 || wr_en !== 1'b1 || wr_dest !== 5'd9) begin
      n_fail++; $display("FAIL sb_clear: busy9=%b wr_en=%b dest=%0d want 0 1 9",
                         busy[9], wr_en, wr_dest);
    end
    rsv_valid = 1'b1; rsv_dest = 5'd9;
    tick();
    n_tests++;
    if (busy[9] !== 1'b1 || wr_en !== 1'b1 || wr_dest !== 5'd9) begin
      n_fail++; $display("FAIL sb_set_wins: busy9=%b wr_en=%b dest=%0d want 1 1 9",
                         busy[9], wr_en, wr_dest);
    end
    rsv_valid = 1'b0; b_valid = 1'b0;
    tick();
    n_tests++;
    if (busy !== 32'h0000_0200) begin
      n_fail++; $display("FAIL sb_hold: busy=%h want 00000200", busy);
    end
    b_valid = 1'b1;
    tick();
    idle();
    n_tests++;
    if (busy !== 32'h0) begin
      n_fail++; $display("FAIL sb_final_clear: busy=%h want 0", busy);
    end
  endtask

  task automatic test_r0();
    tick();
    a_valid = 1'b1; a_dest = 5'd0; a_data = 32'h0000_0055;
    rsv_valid = 1'b1; rsv_dest = 5'd0;
    #1;
    n_tests++;
    if (a_ready !== 1'b1) begin
      n_fail++; $display("FAIL r0_ready: got %b want 1", a_ready);
    end
    tick();
    n_tests++;
    if (wr_en !== 1'b0) begin
      n_fail++; $display("FAIL r0_wr_en: got %b want 0", wr_en);
    end
    n_tests++;
    if (busy !== 32'h0) begin
      n_fail++; $display("FAIL r0_busy: got %h want 0", busy);
    end
    idle();
  endtask

  task automatic test_b_alone();
    tick();
    b_valid = 1'b1; b_dest = 5'd31; b_data = 32'h0000_3131;
    #1;
    n_tests++;
    if (b_ready !== 1'b1 || a_ready !== 1'b1) begin
      n_fail++; $display("FAIL b_alone_ready: b_ready=%b a_ready=%b want 1 1", b_ready, a_ready);
    end
    tick();
    n_tests++;
    if (wr_en !== 1'b1 || wr_dest !== 5'd31 || wr_data !== 32'h0000_3131) begin
      n_fail++; $display("FAIL b_alone_write: wr_en=%b dest=%0d data=%h want 1 31 3131",
                         wr_en, wr_dest, wr_data);
    end
    n_tests++;
    if (dut.r_starve_cnt !== 4'd0) begin
      n_fail++; $display("FAIL b_alone_cnt: got %0d want 0", dut.r_starve_cnt);
    end
    idle();
    tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_a_only();
    test_contention();
    test_scoreboard();
    test_r0();
    test_b_alone();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
